// File: rtl/fifo_access_scheduler.sv
// Arbitrates N_REQ producers and one consumer onto a single shared synchronous FIFO.
// Writes rotate round-robin, and reads alternate with writes when both contend.
module fifo_access_scheduler #(
  parameter int N_REQ = 4,
  parameter int DW    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  output logic [2:0]          grant_id,
  input  logic                cons_rd_req,
  output logic                cons_valid,
  output logic [DW-1:0]       cons_data,
  output logic                fifo_wr,
  output logic [DW-1:0]       fifo_din,
  output logic                fifo_rd,
  input  logic [DW-1:0]       fifo_dout,
  input  logic                fifo_full,
  input  logic                fifo_empty
);

  typedef enum logic {LAST_WR, LAST_RD} op_state_t;

  op_state_t     op_state_reg, op_state_next;
  logic [2:0]    rr_last_reg, rr_last_next;
  logic          hold_reg;
  logic          cons_valid_reg;
  logic [DW-1:0] cons_data_reg;
  logic [DW-1:0] data_arr [8];
  logic [7:0]    valid_ext;
  logic [2:0]    winner;
  logic          active, wr_cand, rd_cand, do_wr, do_rd;

  // Widen ports to 8 lanes so 3-bit indices select without truncation.
  assign valid_ext = 8'(req_valid);

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      if (gi < N_REQ) begin : g_used
        assign data_arr[gi]  = req_data[gi*DW +: DW];
        assign req_ready[gi] = do_wr && (winner == 3'(gi));
      end else begin : g_unused
        assign data_arr[gi] = '0;
      end
    end
  endgenerate

  // Descending scan: the last hit is the nearest requester after rr_last.
  always_comb begin
    winner = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      if (valid_ext[3'((int'(rr_last_reg) + k) % N_REQ)])
        winner = 3'((int'(rr_last_reg) + k) % N_REQ);
    end
  end

  // hold_reg masks the first cycle after reset release.
  assign active  = !rst && !hold_reg;
  assign wr_cand = (|req_valid) && !fifo_full;
  assign rd_cand = cons_rd_req && !fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_state_reg <= LAST_RD;
      rr_last_reg  <= 3'(N_REQ - 1);
      hold_reg     <= 1'b1;
    end else begin
      op_state_reg <= op_state_next;
      rr_last_reg  <= rr_last_next;
      hold_reg     <= 1'b0;
    end
  end

  always_comb begin
    op_state_next = op_state_reg;
    rr_last_next  = rr_last_reg;
    do_wr         = 1'b0;
    do_rd         = 1'b0;
    if (active) begin
      if (wr_cand && (!rd_cand || op_state_reg == LAST_RD))
        do_wr = 1'b1;
      else if (rd_cand)
        do_rd = 1'b1;
    end
    if (do_wr) begin
      op_state_next = LAST_WR;
      rr_last_next  = winner;
    end else if (do_rd) begin
      op_state_next = LAST_RD;
    end
  end

  assign fifo_wr  = do_wr;
  assign fifo_rd  = do_rd;
  assign fifo_din = do_wr ? data_arr[winner] : '0;
  assign grant_id = do_wr ? winner : 3'd0;

  // fifo_dout presents the head word, so it is captured on the popping edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cons_valid_reg <= 1'b0;
      cons_data_reg  <= '0;
    end else begin
      cons_valid_reg <= do_rd;
      if (do_rd) cons_data_reg <= fifo_dout;
    end
  end

  // A read delivered into a reset cycle is squashed immediately.
  assign cons_valid = cons_valid_reg && !rst;
  assign cons_data  = rst ? '0 : cons_data_reg;

endmodule

// File: tb/tb_fifo_access_scheduler.sv
// Bench for fifo_access_scheduler: behavioural FIFO, negedge scoreboard monitor,
// and one task per scenario.
module tb_fifo_access_scheduler;

  localparam int N_REQ = 4;
  localparam int DW    = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       req_valid = '0;
  logic [31:0]      req_data = '0;
  logic [3:0]       req_ready;
  logic [2:0]       grant_id;
  logic             cons_rd_req = 1'b0;
  logic             cons_valid;
  logic [7:0]       cons_data;
  logic             fifo_wr, fifo_rd;
  logic [7:0]       fifo_din, fifo_dout;
  logic             fifo_full, fifo_empty;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fifo_access_scheduler #(.N_REQ(N_REQ), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .grant_id(grant_id), .cons_rd_req(cons_rd_req),
    .cons_valid(cons_valid), .cons_data(cons_data),
    .fifo_wr(fifo_wr), .fifo_din(fifo_din), .fifo_rd(fifo_rd),
    .fifo_dout(fifo_dout), .fifo_full(fifo_full), .fifo_empty(fifo_empty)
  );

  // Behavioural 16x8 FIFO with head word always presented on fifo_dout.
  logic [7:0] fmem [16];
  logic [3:0] wp, rp;
  logic [4:0] cnt;

  always @(posedge clk) begin
    if (rst) begin
      wp <= '0; rp <= '0; cnt <= '0;
    end else begin
      if (fifo_wr && cnt != 5'd16) begin
        fmem[wp] <= fifo_din;
        wp <= wp + 4'd1;
      end
      if (fifo_rd && cnt != 5'd0) rp <= rp + 4'd1;
      if ((fifo_wr && cnt != 5'd16) && !(fifo_rd && cnt != 5'd0)) cnt <= cnt + 5'd1;
      else if (!(fifo_wr && cnt != 5'd16) && (fifo_rd && cnt != 5'd0)) cnt <= cnt - 5'd1;
    end
  end

  assign fifo_full  = (cnt == 5'd16);
  assign fifo_empty = (cnt == 5'd0);
  assign fifo_dout  = fmem[rp];

  // Scoreboard monitor: expected words pushed on each write, popped on each read.
  logic [7:0] sb [$];
  logic       rd_pend = 1'b0;
  logic [7:0] rd_exp = '0;
  int         wait_cnt [4];

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        rd_pend = 1'b0;
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
      end else begin
        checks++;
        if (fifo_wr && fifo_rd) begin
          errors++;
          $display("FAIL wr_rd_overlap: fifo_wr=%0b fifo_rd=%0b required not both 1", fifo_wr, fifo_rd);
        end
        checks++;
        if (rd_pend) begin
          if (cons_valid !== 1'b1 || cons_data !== rd_exp) begin
            errors++;
            $display("FAIL cons_out: cons_valid=%0b cons_data=%02h required 1/%02h", cons_valid, cons_data, rd_exp);
          end
        end else if (cons_valid !== 1'b0) begin
          errors++;
          $display("FAIL cons_spurious: cons_valid=%0b required 0", cons_valid);
        end
        rd_pend = 1'b0;
        if (fifo_rd) begin
          checks++;
          if (fifo_empty || sb.size() == 0) begin
            errors++;
            $display("FAIL rd_when_empty: fifo_rd=1 with fifo_empty=%0b sb_size=%0d required no read", fifo_empty, sb.size());
          end else begin
            rd_exp  = sb.pop_front();
            rd_pend = 1'b1;
          end
        end
        checks++;
        if (fifo_wr) begin
          if (fifo_full || req_ready !== (4'b1 << grant_id) || !req_valid[grant_id] ||
              fifo_din !== req_data[grant_id*8 +: 8]) begin
            errors++;
            $display("FAIL wr_grant: full=%0b ready=%04b grant=%0d din=%02h required not full, ready one-hot at grant, din=%02h",
                     fifo_full, req_ready, grant_id, fifo_din, req_data[grant_id*8 +: 8]);
          end
          sb.push_back(req_data[grant_id*8 +: 8]);
          for (int i = 0; i < 4; i++) begin
            if (i == int'(grant_id)) begin
              checks++;
              if (wait_cnt[i] > N_REQ - 1) begin
                errors++;
                $display("FAIL fairness: producer %0d waited %0d writes required <= %0d", i, wait_cnt[i], N_REQ - 1);
              end
              wait_cnt[i] = 0;
            end else if (req_valid[i]) begin
              wait_cnt[i]++;
            end
          end
        end else if (req_ready !== 4'b0) begin
          errors++;
          $display("FAIL ready_no_wr: req_ready=%04b required 0000", req_ready);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req_valid = '0; cons_rd_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 4'hF; cons_rd_req = 1'b1; req_data = 32'h13121110;
    for (int c = 0; c < 2; c++) begin
      #2; checks++;
      if (req_ready !== 4'b0 || fifo_wr !== 1'b0 || fifo_rd !== 1'b0 || cons_valid !== 1'b0 ||
          cons_data !== 8'h00 || grant_id !== 3'd0) begin
        errors++;
        $display("FAIL reset_outputs: ready=%04b wr=%0b rd=%0b cv=%0b cd=%02h gid=%0d required all 0",
                 req_ready, fifo_wr, fifo_rd, cons_valid, cons_data, grant_id);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #2; checks++;
    if (req_ready !== 4'b0 || fifo_wr !== 1'b0 || cons_valid !== 1'b0 || grant_id !== 3'd0) begin
      errors++;
      $display("FAIL release_cycle: ready=%04b wr=%0b cv=%0b gid=%0d required all 0", req_ready, fifo_wr, cons_valid, grant_id);
    end
    @(posedge clk); #3; checks++;
    if (fifo_wr !== 1'b1 || grant_id !== 3'd0) begin
      errors++;
      $display("FAIL first_grant: wr=%0b gid=%0d required 1/0", fifo_wr, grant_id);
    end
    req_valid = '0; cons_rd_req = 1'b0;
  endtask

  task automatic test_round_robin();
    do_reset();
    req_data = 32'h13121110; req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      #2; checks++;
      if (fifo_wr !== 1'b1 || grant_id !== 3'(k % 4)) begin
        errors++;
        $display("FAIL rr_order: step %0d wr=%0b gid=%0d required 1/%0d", k, fifo_wr, grant_id, k % 4);
      end
    end
    @(posedge clk); #1; req_valid = '0; #2;
    checks++;
    if (cnt !== 5'd8) begin
      errors++;
      $display("FAIL rr_count: fifo count=%0d required 8", cnt);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (fmem[i] !== 8'(8'h10 + i)) begin
        errors++;
        $display("FAIL rr_contents: slot %0d=%02h required %02h", i, fmem[i], 8'(8'h10 + i));
      end
    end
  endtask

  task automatic test_full();
    int n = 0;
    bit seen;
    do_reset();
    req_valid = 4'b0100;
    for (int c = 0; c < 40; c++) begin
      req_data[23:16] = 8'(8'h40 + n);
      #2;
      if (req_ready[2]) n++;
      if (fifo_full) break;
      @(posedge clk); #1;
    end
    checks++;
    if (n != 16 || !fifo_full) begin
      errors++;
      $display("FAIL fill_count: writes=%0d full=%0b required 16/1", n, fifo_full);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #3; checks++;
      if (fifo_wr !== 1'b0 || req_ready !== 4'b0) begin
        errors++;
        $display("FAIL write_while_full: wr=%0b ready=%04b required 0/0000", fifo_wr, req_ready);
      end
    end
    @(posedge clk); #1; cons_rd_req = 1'b1; #2; checks++;
    if (fifo_rd !== 1'b1 || fifo_wr !== 1'b0) begin
      errors++;
      $display("FAIL read_when_full: rd=%0b wr=%0b required 1/0", fifo_rd, fifo_wr);
    end
    seen = 0;
    for (int c = 0; c < 2 && !seen; c++) begin
      @(posedge clk); #1; cons_rd_req = 1'b0; #2;
      if (fifo_wr === 1'b1 && grant_id === 3'd2) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL resume_after_full: no write to producer 2 within 2 cycles, required one");
    end
    req_valid = '0;
  endtask

  task automatic test_alternation();
    do_reset();
    req_data[7:0] = 8'h50; req_data[15:8] = 8'h60; req_valid = 4'b0011;
    @(posedge clk); #1;
    @(posedge clk); #1; cons_rd_req = 1'b1;
    for (int j = 0; j < 10; j++) begin
      if (j > 0) begin @(posedge clk); #1; end
      #2; checks++;
      if (fifo_rd !== 1'(j % 2 == 0) || fifo_wr !== 1'(j % 2 == 1) ||
          (j % 2 == 1 && grant_id !== 3'((j / 2) % 2))) begin
        errors++;
        $display("FAIL alternation: step %0d rd=%0b wr=%0b gid=%0d required rd=%0b wr=%0b gid=%0d",
                 j, fifo_rd, fifo_wr, grant_id, j % 2 == 0, j % 2 == 1, (j / 2) % 2);
      end
    end
    @(posedge clk); #1; cons_rd_req = 1'b0; req_valid = '0;
  endtask

  task automatic test_empty();
    do_reset();
    cons_rd_req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      #2; checks++;
      if (fifo_rd !== 1'b0 || cons_valid !== 1'b0) begin
        errors++;
        $display("FAIL read_when_empty: rd=%0b cv=%0b required 0/0", fifo_rd, cons_valid);
      end
    end
    @(posedge clk); #1; req_data[31:24] = 8'hA5; req_valid = 4'b1000; #2; checks++;
    if (fifo_wr !== 1'b1 || grant_id !== 3'd3 || fifo_rd !== 1'b0) begin
      errors++;
      $display("FAIL empty_write: wr=%0b gid=%0d rd=%0b required 1/3/0", fifo_wr, grant_id, fifo_rd);
    end
    @(posedge clk); #1; req_valid = '0; #2; checks++;
    if (fifo_rd !== 1'b1) begin
      errors++;
      $display("FAIL read_after_fill: rd=%0b required 1", fifo_rd);
    end
    @(posedge clk); #3; checks++;
    if (cons_valid !== 1'b1 || cons_data !== 8'hA5 || fifo_rd !== 1'b0) begin
      errors++;
      $display("FAIL empty_data: cv=%0b cd=%02h rd=%0b required 1/a5/0", cons_valid, cons_data, fifo_rd);
    end
    cons_rd_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_data[7:0] = 8'h31; req_valid = 4'b0001;
    @(posedge clk); #1; req_data[7:0] = 8'h32;
    @(posedge clk); #1; req_valid = '0; cons_rd_req = 1'b1; #2; checks++;
    if (fifo_rd !== 1'b1) begin
      errors++;
      $display("FAIL mid_read: rd=%0b required 1", fifo_rd);
    end
    @(posedge clk); #1; rst = 1'b1; cons_rd_req = 1'b0; req_valid = 4'b1110; #2; checks++;
    if (cons_valid !== 1'b0 || fifo_wr !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_cv: cv=%0b wr=%0b required 0/0", cons_valid, fifo_wr);
    end
    @(posedge clk); #1; rst = 1'b0; req_valid = 4'hF; #2; checks++;
    if (fifo_wr !== 1'b0 || cons_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_release: wr=%0b cv=%0b required 0/0", fifo_wr, cons_valid);
    end
    @(posedge clk); #3; checks++;
    if (fifo_wr !== 1'b1 || grant_id !== 3'd0) begin
      errors++;
      $display("FAIL mid_priority: wr=%0b gid=%0d required 1/0", fifo_wr, grant_id);
    end
    req_valid = '0;
  endtask

  task automatic test_random();
    logic [3:0] rdy = '0;
    int wr_hs = 0;
    int rd_iss = 0;
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (rdy[i] || !req_valid[i]) begin
          req_valid[i] = 1'(($urandom % 3) == 0);
          req_data[i*8 +: 8] = 8'($urandom);
        end
      end
      cons_rd_req = 1'($urandom % 2);
      #2;
      rdy = req_ready;
      wr_hs += $countones(req_valid & req_ready);
      if (fifo_rd) rd_iss++;
      @(posedge clk); #1;
    end
    req_valid = '0; cons_rd_req = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #2;
      if (fifo_rd) rd_iss++;
      @(posedge clk); #1;
    end
    cons_rd_req = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (wr_hs != rd_iss || sb.size() != 0 || cnt !== 5'd0) begin
      errors++;
      $display("FAIL random_drain: writes=%0d reads=%0d sb=%0d count=%0d required equal/0/0", wr_hs, rd_iss, sb.size(), cnt);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_full();
    test_alternation();
    test_empty();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
